// File: rtl/elevator_pkg.sv
// Types shared by the request scheduler and the car controller.
package elevator_pkg;

  localparam int FLOOR_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PICK   = 2'd1,
    ST_OFFER  = 2'd2,
    ST_TRAVEL = 2'd3
  } sched_state_e;

endpackage

// File: rtl/elevator_look_picker.sv
// LOOK target selection: lowest pending floor at/above the car when sweeping up,
// highest at/below when sweeping down, reversing only when nothing lies ahead.
module elevator_look_picker
  import elevator_pkg::*;
#(
  parameter int FLOORS  = 16,
  parameter int FLOOR_W = FLOOR_W_DEFAULT
) (
  input  logic [FLOORS-1:0]  pending,
  input  logic [FLOOR_W-1:0] current_floor,
  input  logic               sweep_up,
  output logic               found,
  output logic [FLOOR_W-1:0] pick_floor,
  output logic               new_sweep_up
);

  int  cur;
  int  lo_ge;
  int  hi_le;
  logic any_ge;
  logic any_le;

  // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latch).
  always_comb begin
    cur    = (int'(current_floor) >= FLOORS) ? FLOORS - 1 : int'(current_floor);
    lo_ge  = 0;
    hi_le  = 0;
    any_ge = 1'b0;
    any_le = 1'b0;

    // Descending scan: the last hit is the lowest index at/above the car.
    for (int i = FLOORS - 1; i >= 0; i--) begin
      if (pending[i] && i >= cur) begin
        lo_ge  = i;
        any_ge = 1'b1;
      end
    end
    // Ascending scan: the last hit is the highest index at/below the car.
    for (int i = 0; i < FLOORS; i++) begin
      if (pending[i] && i <= cur) begin
        hi_le  = i;
        any_le = 1'b1;
      end
    end

    found = |pending;
    // With nothing ahead, every pending floor is behind, so the opposite scan
    // already yields the nearest floor in the reversed direction.
    if (sweep_up) begin
      new_sweep_up = any_ge;
      pick_floor   = any_ge ? FLOOR_W'(lo_ge) : FLOOR_W'(hi_le);
    end else begin
      new_sweep_up = !any_le;
      pick_floor   = any_le ? FLOOR_W'(hi_le) : FLOOR_W'(lo_ge);
    end
  end

endmodule

// File: rtl/elevator_request_scheduler.sv
// Collects floor calls and dispatches LOOK-ordered targets over valid/ready.
// Optional arrival watchdog and timeout_flag port: define ELEV_SCHED_TIMEOUT_EN.
module elevator_request_scheduler
  import elevator_pkg::*;
#(
  parameter int FLOORS         = 16,
  parameter int FLOOR_W        = FLOOR_W_DEFAULT,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FLOORS-1:0]  call_req,
  input  logic [FLOOR_W-1:0] current_floor,
  input  logic               arrived,
  output logic               target_valid,
  input  logic               target_ready,
  output logic [FLOOR_W-1:0] target_floor,
  output logic               sweep_up,
  output logic [FLOORS-1:0]  pending,
  output logic               busy
`ifdef ELEV_SCHED_TIMEOUT_EN
  ,
  output logic               timeout_flag
`endif
);

  if (FLOORS < 2 || FLOORS > 16 || FLOOR_W < $clog2(FLOORS)) begin : g_bad_floors
    $error("elevator_request_scheduler: unsupported FLOORS/FLOOR_W");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("elevator_request_scheduler: TIMEOUT_CYCLES must be >= 1");
  end

  sched_state_e       state_q, state_d;
  logic [FLOORS-1:0]  pending_q, pending_d;
  logic [FLOOR_W-1:0] target_q, target_d;
  logic               sweep_up_q, sweep_up_d;
  logic               target_valid_q, target_valid_d;
  logic               busy_q, busy_d;

  logic               found;
  logic [FLOOR_W-1:0] pick_floor;
  logic               new_sweep_up;
  logic               timeout_hit;
  logic               retire;

  elevator_look_picker #(
    .FLOORS  (FLOORS),
    .FLOOR_W (FLOOR_W)
  ) u_picker (
    .pending      (pending_q),
    .current_floor(current_floor),
    .sweep_up     (sweep_up_q),
    .found        (found),
    .pick_floor   (pick_floor),
    .new_sweep_up (new_sweep_up)
  );

`ifdef ELEV_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_flag_q, timeout_flag_d;

  // Counter is zero on TRAVEL entry; an arrival in the final cycle beats the timeout.
  always_comb begin
    tmo_cnt_d   = '0;
    timeout_hit = 1'b0;
    if (state_q == ST_TRAVEL && !arrived) begin
      if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) timeout_hit = 1'b1;
      else                                         tmo_cnt_d   = tmo_cnt_q + 1'b1;
    end
    timeout_flag_d = timeout_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q      <= '0;
      timeout_flag_q <= 1'b0;
    end else begin
      tmo_cnt_q      <= tmo_cnt_d;
      timeout_flag_q <= timeout_flag_d;
    end
  end

  assign timeout_flag = timeout_flag_q;
`else
  assign timeout_hit = 1'b0;
`endif

  assign retire = (state_q == ST_TRAVEL) && (arrived || timeout_hit);

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    sweep_up_d = sweep_up_q;
    // The clear is applied after the OR so a same-cycle call for the served floor is dropped.
    pending_d  = (pending_q | call_req) & ~(retire ? (FLOORS'(1) << target_q) : '0);

    unique case (state_q)
      ST_IDLE:   if (|pending_q) state_d = ST_PICK;
      ST_PICK: begin
        if (found) begin
          target_d   = pick_floor;
          sweep_up_d = new_sweep_up;
          state_d    = ST_OFFER;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_OFFER:  if (target_ready) state_d = ST_TRAVEL;
      ST_TRAVEL: if (retire)       state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    target_valid_d = (state_d == ST_OFFER);
    busy_d         = (state_d == ST_TRAVEL);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      pending_q      <= '0;
      target_q       <= '0;
      sweep_up_q     <= 1'b1;
      target_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      target_q       <= target_d;
      sweep_up_q     <= sweep_up_d;
      target_valid_q <= target_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign target_valid = target_valid_q;
  assign target_floor = target_q;
  assign sweep_up     = sweep_up_q;
  assign pending      = pending_q;
  assign busy         = busy_q;

endmodule
